lisa_dmem_responder: RTL and testbench

Memory-side responder that serves the LISA load/store unit's data requests. It accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs the word read or write on an internal RAM array, and returns a response with read data and an error flag. It sits between the LSU's memory port and the data storage, as the responder end of the LSU memory interface.

---
 rtl/lisa_dmem_responder_if.sv | 24 ++
 rtl/lisa_dmem_responder.sv | 116 +++++++++++
 tb/tb_lisa_dmem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lisa_dmem_responder_if.sv
// LSU data-memory port: request channel (initiator -> responder) and response channel back.
// Latency: none, wires only.
// Backpressure: valid/ready on both channels; req_ready from responder, rsp_ready from initiator.
interface lisa_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lisa_dmem_responder.sv
// Data-memory responder for the LISA LSU: one word access at a time against an internal RAM.
// Latency: WAIT_CYCLES + 1 cycles from request accept to rsp_valid.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
module lisa_dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lisa_dmem_responder_if.slave    bus,
    output logic                    busy
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_C = 17'(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mem_we;
    logic        in_range;
    logic [AW-1:0] idx;
    logic        accept;

    logic [31:0] mem [DEPTH];

    // Full 16-bit compare first; the RAM index only uses the low bits once in range.
    assign in_range = ({1'b0, addr_q} < DEPTH_C);
    assign idx      = addr_q[AW-1:0];
    assign accept   = (state_q == IDLE) && bus.req_valid;

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state_q != IDLE);

    // Next-state and response-data decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = (WAIT_CYCLES > 0) ? WAIT : EXEC;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            EXEC: begin
                mem_we  = we_q && in_range;
                rdata_d = (!we_q && in_range) ? mem[idx] : 32'd0;
                err_d   = !in_range;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, wait counter and response registers; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request holding registers, loaded only on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // RAM write port; contents survive reset, but a reset on the EXEC edge cancels the store.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_lisa_dmem_responder.sv
// Bench for lisa_dmem_responder: three instances (WAIT_CYCLES 1, 0, 3) sharing one clock.
// Transaction-level model predicts every output each cycle; directed vectors add literal checks.
// Responses are stalled and a request is parked during the stall to exercise backpressure.
module tb_lisa_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam int WC [3] = '{1, 0, 3};

    logic [2:0]        tb_rst = 3'b000;
    logic [2:0]        tb_rv  = 3'b000;
    logic [2:0]        tb_we  = 3'b000;
    logic [2:0]        tb_rr  = 3'b000;
    logic [2:0][15:0]  tb_addr = '0;
    logic [2:0][31:0]  tb_wd   = '0;

    logic [2:0]        o_reqrdy, o_rv, o_err, o_busy;
    logic [2:0][31:0]  o_rd;

    lisa_dmem_responder_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].req_valid = tb_rv[g];
        assign bus[g].req_we    = tb_we[g];
        assign bus[g].req_addr  = tb_addr[g];
        assign bus[g].req_wdata = tb_wd[g];
        assign bus[g].rsp_ready = tb_rr[g];
        assign o_reqrdy[g]      = bus[g].req_ready;
        assign o_rv[g]          = bus[g].rsp_valid;
        assign o_rd[g]          = bus[g].rsp_rdata;
        assign o_err[g]         = bus[g].rsp_err;

        lisa_dmem_responder #(
            .DEPTH       (1024),
            .WAIT_CYCLES (WC[g])
        ) u_dut (
            .clk   (clk),
            .rst_n (tb_rst[g]),
            .bus   (bus[g]),
            .busy  (o_busy[g])
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_on   [3];
    bit          m_busy [3];
    bit          m_rv   [3];
    bit          m_err  [3];
    bit [31:0]   m_rd   [3];
    int          m_cnt  [3];
    bit          m_we   [3];
    bit [15:0]   m_addr [3];
    bit [31:0]   m_wd   [3];
    bit [31:0]   mmem   [3][1024];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!tb_rst[k]) begin
                m_on[k] = 1'b1; m_busy[k] = 1'b0; m_rv[k] = 1'b0;
                m_rd[k] = 32'd0; m_err[k] = 1'b0;
            end else if (!m_busy[k]) begin
                if (tb_rv[k]) begin
                    m_busy[k] = 1'b1;
                    m_cnt[k]  = WC[k] + 1;   // edges until response is visible
                    m_we[k]   = tb_we[k];
                    m_addr[k] = tb_addr[k];
                    m_wd[k]   = tb_wd[k];
                end
            end else if (!m_rv[k]) begin
                m_cnt[k]--;
                if (m_cnt[k] == 0) begin
                    if (m_addr[k] < 16'd1024) begin
                        if (m_we[k]) mmem[k][m_addr[k][9:0]] = m_wd[k];
                        m_rd[k]  = m_we[k] ? 32'd0 : mmem[k][m_addr[k][9:0]];
                        m_err[k] = 1'b0;
                    end else begin
                        m_rd[k]  = 32'd0;
                        m_err[k] = 1'b1;
                    end
                    m_rv[k] = 1'b1;
                end
            end else if (tb_rr[k]) begin
                m_rv[k] = 1'b0; m_rd[k] = 32'd0; m_err[k] = 1'b0; m_busy[k] = 1'b0;
            end
        end
    end

    // Compare every instance against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (m_on[k]) begin
                chk($sformatf("i%0d_req_ready", k), 32'(o_reqrdy[k]), 32'(!m_busy[k]));
                chk($sformatf("i%0d_busy", k),      32'(o_busy[k]),   32'(m_busy[k]));
                chk($sformatf("i%0d_rsp_valid", k), 32'(o_rv[k]),     32'(m_rv[k]));
                chk($sformatf("i%0d_rsp_rdata", k), o_rd[k],          m_rd[k]);
                chk($sformatf("i%0d_rsp_err", k),   32'(o_err[k]),    32'(m_err[k]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present a request and return how many edges passed before it was accepted.
    task automatic send(input int k, input logic we, input logic [15:0] a,
                        input logic [31:0] d, output int waited);
        logic rr;
        tb_we[k] = we; tb_addr[k] = a; tb_wd[k] = d; tb_rv[k] = 1'b1;
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rr = o_reqrdy[k];
            @(posedge clk);
            if (rr) break;
            waited++;
        end
        if (waited >= 40) timeout_fail($sformatf("i%0d_accept", k));
        #1;
        tb_rv[k] = 1'b0;
        // Scramble request fields after accept; they must have no effect.
        tb_we[k] = 1'($urandom); tb_addr[k] = 16'($urandom); tb_wd[k] = $urandom;
    endtask

    // Wait for the response, optionally stalling it and parking a load to na meanwhile.
    task automatic get_rsp(input int k, input int stall, input bit arm, input logic [15:0] na,
                           output logic [31:0] rd, output logic err, output int lat);
        bit seen = 1'b0;
        tb_rr[k] = (stall == 0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (o_rv[k]) begin seen = 1'b1; break; end
        end
        if (!seen) timeout_fail($sformatf("i%0d_rsp_valid", k));
        rd  = o_rd[k];
        err = o_err[k];
        if (stall > 0) begin
            if (arm) begin
                tb_we[k] = 1'b0; tb_addr[k] = na; tb_wd[k] = 32'd0; tb_rv[k] = 1'b1;
            end
            repeat (stall) @(posedge clk);
            #1 tb_rr[k] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input int k, input logic we, input logic [15:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int w, lat;
        logic [31:0] rd;
        logic err;
        send(k, we, a, d, w);
        get_rsp(k, 0, 1'b0, 16'd0, rd, err, lat);
        chk($sformatf("i%0d_rdata_%h", k, a), rd, exp_rd);
        chk($sformatf("i%0d_err_%h", k, a), 32'(err), 32'(exp_err));
        chk($sformatf("i%0d_latency_%h", k, a), 32'(lat), 32'(exp_lat));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w, lat;
        logic [31:0] rd;
        logic err;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(o_reqrdy[0]), 32'd1);
        chk("rst_rsp_valid", 32'(o_rv[0]),     32'd0);
        chk("rst_rsp_rdata", o_rd[0],          32'd0);
        chk("rst_busy",      32'(o_busy[0]),   32'd0);
        @(posedge clk);
        #1 tb_rst = 3'b111;
        @(posedge clk);
        #1;

        // WAIT_CYCLES = 1: basic store/load and range errors
        txn(0, 1'b1, 16'h0005, 32'hDEADBEEF, 32'h0,        1'b0, 2);
        txn(0, 1'b0, 16'h0005, 32'h0,        32'hDEADBEEF, 1'b0, 2);
        txn(0, 1'b1, 16'h03FF, 32'hAAAA5555, 32'h0,        1'b0, 2);
        txn(0, 1'b0, 16'h0400, 32'h0,        32'h0,        1'b1, 2);
        txn(0, 1'b1, 16'hFFFF, 32'h12345678, 32'h0,        1'b1, 2);
        txn(0, 1'b0, 16'h03FF, 32'h0,        32'hAAAA5555, 1'b0, 2);
        txn(0, 1'b1, 16'h0405, 32'h0BADF00D, 32'h0,        1'b1, 2);
        txn(0, 1'b0, 16'h0005, 32'h0,        32'hDEADBEEF, 1'b0, 2);

        // Backpressure: 5-cycle stall with a load parked on the request channel
        send(0, 1'b0, 16'h0005, 32'h0, w);
        get_rsp(0, 5, 1'b1, 16'h03FF, rd, err, lat);
        chk("bp_rdata", rd, 32'hDEADBEEF);
        chk("bp_latency", 32'(lat), 32'd2);
        send(0, 1'b0, 16'h03FF, 32'h0, w);
        chk("bp_accept_after_hs", 32'(w), 32'd0);
        get_rsp(0, 0, 1'b0, 16'd0, rd, err, lat);
        chk("bp_next_rdata", rd, 32'hAAAA5555);

        // WAIT_CYCLES = 0
        txn(1, 1'b1, 16'h0007, 32'h01020304, 32'h0,        1'b0, 1);
        txn(1, 1'b0, 16'h0007, 32'h0,        32'h01020304, 1'b0, 1);

        // WAIT_CYCLES = 3, with a reset landing in WAIT of a store
        txn(2, 1'b1, 16'h0010, 32'h11111111, 32'h0,        1'b0, 4);
        send(2, 1'b1, 16'h0010, 32'h22222222, w);
        @(posedge clk);
        #1 tb_rst[2] = 1'b0;
        @(posedge clk);
        #1 tb_rst[2] = 1'b1;
        @(negedge clk);
        chk("rstmid_busy",      32'(o_busy[2]), 32'd0);
        chk("rstmid_rsp_valid", 32'(o_rv[2]),   32'd0);
        repeat (6) @(posedge clk);
        #1;
        txn(2, 1'b0, 16'h0010, 32'h0,        32'h11111111, 1'b0, 4);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
